// File: rtl/syn_debug_scanner_if.sv
// Word stream from the debug scanner towards the host link.
// Index width follows `DM_ADDR_BIT (6 when not defined externally).
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 6
`endif

interface syn_debug_scanner_if;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_data;
  logic [1:0]              out_kind;
  logic [`DM_ADDR_BIT-1:0] out_index;
  logic                    out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_kind,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_kind,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/syn_debug_scanner.sv
// Debug scanner: freezes the CPU, then streams PC, RF0..RF31 and DM0..DM_WORDS-1 as words.
// Build option DBG_SCAN_SKIP_ZERO_EN drops zero RF/DM words (PC and the final DM word always go out).
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 6
`endif

module syn_debug_scanner #(
  parameter int unsigned DM_WORDS = 64,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    cpu_hold,
  output logic [4:0]              regfile_req_dbg,
  input  logic [31:0]             regfile_data_dbg,
  output logic [`DM_ADDR_BIT-1:0] datamem_addr_dbg,
  input  logic [31:0]             datamem_data_dbg,
  input  logic [31:0]             pc_dbg,
  syn_debug_scanner_if.master     out_if,
  output logic                    busy
);
  localparam int unsigned AW = `DM_ADDR_BIT;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] DM_LAST = AW'(DM_WORDS - 1);
  localparam logic [1:0] K_PC = 2'd0;
  localparam logic [1:0] K_RF = 2'd1;
  localparam logic [1:0] K_DM = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_REQ, S_WAIT, S_OUT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    kind_q, kind_d;
  logic [4:0]    rf_idx_q, rf_idx_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;
  logic [4:0]    rf_req_q, rf_req_d;
  logic [AW-1:0] dm_req_q, dm_req_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    okind_q, okind_d;
  logic [AW-1:0] oidx_q, oidx_d;

  logic          is_last_c;
  logic          skip_c;
  logic [31:0]   src_data_c;
  logic [AW-1:0] src_index_c;
  logic [1:0]    nxt_kind_c;
  logic [4:0]    nxt_rf_c;
  logic [AW-1:0] nxt_dm_c;

  // Data and index belonging to the current cursor position.
  always_comb begin
    is_last_c   = (kind_q == K_DM) && (dm_addr_q == DM_LAST);
    src_data_c  = pc_dbg;
    src_index_c = '0;
    case (kind_q)
      K_RF: begin
        src_data_c  = regfile_data_dbg;
        src_index_c = AW'(rf_idx_q);
      end
      K_DM: begin
        src_data_c  = datamem_data_dbg;
        src_index_c = dm_addr_q;
      end
      default: ;
    endcase
  end

  // Cursor successor: PC -> RF0..RF31 -> DM0..; termination is decided on DM_LAST, not on wrap.
  always_comb begin
    nxt_kind_c = kind_q;
    nxt_rf_c   = rf_idx_q;
    nxt_dm_c   = dm_addr_q;
    case (kind_q)
      K_PC: begin
        nxt_kind_c = K_RF;
        nxt_rf_c   = '0;
      end
      K_RF: begin
        if (rf_idx_q == 5'd31) begin
          nxt_kind_c = K_DM;
          nxt_dm_c   = '0;
        end else begin
          nxt_rf_c = rf_idx_q + 5'd1;
        end
      end
      default: nxt_dm_c = dm_addr_q + AW'(1);
    endcase
  end

`ifdef DBG_SCAN_SKIP_ZERO_EN
  assign skip_c = (kind_q != K_PC) && !is_last_c && (src_data_c == 32'd0);
`else
  assign skip_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    rf_idx_d  = rf_idx_q;
    dm_addr_d = dm_addr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    rf_req_d  = rf_req_q;
    dm_req_d  = dm_req_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    okind_d   = okind_q;
    oidx_d    = oidx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        kind_d    = K_PC;
        rf_idx_d  = '0;
        dm_addr_d = '0;
        state_d   = S_REQ;
      end
      S_REQ: begin
        if (kind_q == K_RF) rf_req_d = rf_idx_q;
        if (kind_q == K_DM) dm_req_d = dm_addr_q;
        cnt_d   = CW'(READ_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // The counter reaching zero marks the cycle the requested data is valid.
        if (cnt_q <= CW'(1)) begin
          if (skip_c) begin
            kind_d    = nxt_kind_c;
            rf_idx_d  = nxt_rf_c;
            dm_addr_d = nxt_dm_c;
            state_d   = S_REQ;
          end else begin
            valid_d = 1'b1;
            data_d  = src_data_c;
            okind_d = kind_q;
            oidx_d  = src_index_c;
            last_d  = is_last_c;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            kind_d    = nxt_kind_c;
            rf_idx_d  = nxt_rf_c;
            dm_addr_d = nxt_dm_c;
            state_d   = S_REQ;
          end
        end
      end
      S_DONE: begin
        hold_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      kind_q    <= K_PC;
      rf_idx_q  <= '0;
      dm_addr_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      rf_req_q  <= '0;
      dm_req_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      okind_q   <= '0;
      oidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      rf_idx_q  <= rf_idx_d;
      dm_addr_q <= dm_addr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      rf_req_q  <= rf_req_d;
      dm_req_q  <= dm_req_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      okind_q   <= okind_d;
      oidx_q    <= oidx_d;
    end
  end

  assign cpu_hold         = hold_q;
  assign busy             = busy_q;
  assign regfile_req_dbg  = rf_req_q;
  assign datamem_addr_dbg = dm_req_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_kind  = okind_q;
  assign out_if.out_index = oidx_q;
  assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_syn_debug_scanner.sv
// Directed bench for syn_debug_scanner: word order, latencies, back-pressure, start/rst corners.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 6
`endif

module tb_syn_debug_scanner;
  localparam int unsigned DMW = 64;
  localparam int unsigned RL  = 3;
  localparam int unsigned AW  = `DM_ADDR_BIT;
  localparam int NALL    = 33 + DMW;
  localparam int MAX_CYC = 5000;
`ifdef DBG_SCAN_SKIP_ZERO_EN
  localparam bit SKIP    = 1'b1;
  localparam int STALL_W = 1;
  localparam int POKE_W  = 1;
  localparam int ABORT_W = 1;
`else
  localparam bit SKIP    = 1'b0;
  localparam int STALL_W = 5;
  localparam int POKE_W  = 20;
  localparam int ABORT_W = 40;
`endif

  typedef struct {
    int            stall;
    logic [1:0]    kind;
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic          last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cpu_hold;
  logic          busy;
  logic [4:0]    rf_req;
  logic [AW-1:0] dm_addr;
  logic [31:0]   rf_rd, dm_rd, pc;
  logic [31:0]   rf_mem [32];
  logic [31:0]   dm_mem [DMW];

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t exp_q [$];
  vec_t rx_q  [$];
  int   vcyc_q [$];
  int   hcyc_q [$];
  int   first_lat;
  logic hold_at1;
  bit   scan_done;

  syn_debug_scanner_if bus();

  always #5 clk = ~clk;

  assign rf_rd = rf_mem[rf_req];
  assign dm_rd = dm_mem[dm_addr];

  syn_debug_scanner #(.DM_WORDS(DMW), .READ_LAT(RL)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cpu_hold         (cpu_hold),
    .regfile_req_dbg  (rf_req),
    .regfile_data_dbg (rf_rd),
    .datamem_addr_dbg (dm_addr),
    .datamem_data_dbg (dm_rd),
    .pc_dbg           (pc),
    .out_if           (bus.master),
    .busy             (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [63:0] mk(input logic [1:0] k, input logic [AW-1:0] i,
                                     input logic [31:0] d, input logic l);
    return 64'({k, i, d, l});
  endfunction

  function automatic logic [63:0] pack(input vec_t v);
    return mk(v.kind, v.idx, v.data, v.last);
  endfunction

  function automatic logic [63:0] cur_word();
    return mk(bus.out_kind, bus.out_index, bus.out_data, bus.out_last);
  endfunction

  // Pulses start, then consumes words, applying each table entry's stall before accepting it.
  task automatic run_scan(input int poke_w, input int abort_w, output bit aborted);
    int cyc, stall_left, n;
    bit seen, poked;
    logic [63:0] snap;
    vec_t r;
    rx_q.delete(); vcyc_q.delete(); hcyc_q.delete();
    aborted = 1'b0; scan_done = 1'b0; first_lat = -1; hold_at1 = 1'b0;
    cyc = 0; stall_left = -1; seen = 1'b0; poked = 1'b0; snap = '0;
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    while (!scan_done && !aborted && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) hold_at1 = cpu_hold;
      n = rx_q.size();
      if (!poked && poke_w >= 0 && n == poke_w) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (bus.out_valid) begin
        if (!seen) begin
          vcyc_q.push_back(cyc);
          seen = 1'b1;
          if (first_lat < 0) first_lat = cyc;
        end
        if (n == abort_w) begin
          aborted = 1'b1;
        end else begin
          if (stall_left < 0) stall_left = (n < exp_q.size()) ? exp_q[n].stall : 0;
          if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            if (stall_left == exp_q[n].stall) snap = cur_word();
            else chk("stall_hold", cur_word(), snap);
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
            r.stall = 0; r.kind = bus.out_kind; r.idx = bus.out_index;
            r.data = bus.out_data; r.last = bus.out_last;
            rx_q.push_back(r);
            hcyc_q.push_back(cyc);
            stall_left = -1;
            seen = 1'b0;
            if (bus.out_last) scan_done = 1'b1;
          end
        end
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    if (abort_w < 0) chk("scan_completed", 64'(scan_done), 64'(1));
  endtask

  initial begin
    vec_t e;
    bit   ab, skip;
    int   nl;
    rst = 1'b1; start = 1'b0; bus.out_ready = 1'b0; pc = 32'h0000_0040;
    for (int i = 0; i < 32; i++) rf_mem[i] = SKIP ? 32'd0 : (32'h1000_0000 + 32'(i));
    for (int i = 0; i < DMW; i++) dm_mem[i] = SKIP ? 32'd0 : (32'hA5A5_0000 | 32'(i));
    rf_mem[0] = 32'd0;
    if (SKIP) rf_mem[29] = 32'h0000_2000;
    else begin
      rf_mem[8] = 32'd5;
      dm_mem[3] = 32'hDEAD_BEEF;
    end

    // Expected word table; the stall field is the back-pressure applied to that word.
    for (int w = 0; w < NALL; w++) begin
      e.stall = 0;
      e.last  = (w == NALL - 1);
      if (w == 0) begin
        e.kind = 2'd0; e.idx = '0; e.data = pc;
      end else if (w < 33) begin
        e.kind = 2'd1; e.idx = AW'(w - 1); e.data = rf_mem[w - 1];
      end else begin
        e.kind = 2'd2; e.idx = AW'(w - 33); e.data = dm_mem[w - 33];
      end
      skip = SKIP && (e.kind != 2'd0) && !e.last && (e.data == 32'd0);
      if (!skip) exp_q.push_back(e);
    end
    exp_q[STALL_W].stall = 10;

    repeat (3) @(negedge clk);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_kind", 64'(bus.out_kind), 64'(0));
    chk("rst_out_index", 64'(bus.out_index), 64'(0));
    chk("rst_rf_req", 64'(rf_req), 64'(0));
    chk("rst_dm_addr", 64'(dm_addr), 64'(0));
    rst = 1'b0;

    // Full scan with a mid-scan start pulse and a start in the DONE cycle.
    run_scan(POKE_W, -1, ab);
    @(negedge clk);
    chk("done_cpu_hold", 64'(cpu_hold), 64'(1));
    chk("done_busy", 64'(busy), 64'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("release_cpu_hold", 64'(cpu_hold), 64'(0));
    chk("release_busy", 64'(busy), 64'(0));
    repeat (8) @(negedge clk);
    chk("no_restart_busy", 64'(busy), 64'(0));
    chk("no_restart_valid", 64'(bus.out_valid), 64'(0));
    chk("first_latency", 64'(first_lat), 64'(2 + RL + 1));
    chk("hold_after_start", 64'(hold_at1), 64'(1));
    chk("word_count", 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("word%0d", i), pack(rx_q[i]), pack(exp_q[i]));
    nl = 0;
    foreach (rx_q[i]) if (rx_q[i].last) nl++;
    chk("last_count", 64'(nl), 64'(1));
`ifdef DBG_SCAN_SKIP_ZERO_EN
    chk("skip_count", 64'(rx_q.size()), 64'(3));
    if (rx_q.size() == 3) begin
      chk("skip_pc", pack(rx_q[0]), mk(2'd0, AW'(0), 32'h40, 1'b0));
      chk("skip_sp", pack(rx_q[1]), mk(2'd1, AW'(29), 32'h2000, 1'b0));
      chk("skip_dm63", pack(rx_q[2]), mk(2'd2, AW'(63), 32'd0, 1'b1));
    end
`else
    if (rx_q.size() == 97) begin
      chk("lit_word0", pack(rx_q[0]), mk(2'd0, AW'(0), 32'h40, 1'b0));
      chk("lit_word9", pack(rx_q[9]), mk(2'd1, AW'(8), 32'd5, 1'b0));
      chk("lit_word36", pack(rx_q[36]), mk(2'd2, AW'(3), 32'hDEAD_BEEF, 1'b0));
      chk("lit_word96", pack(rx_q[96]), mk(2'd2, AW'(63), 32'hA5A5_003F, 1'b1));
    end
    if (hcyc_q.size() > 1 && vcyc_q.size() > 2)
      chk("word_gap", 64'(vcyc_q[2] - hcyc_q[1]), 64'(RL + 2));
`endif

    // Reset while a word is pending, then a fresh scan from the PC word.
    run_scan(-1, ABORT_W, ab);
    chk("abort_reached", 64'(ab), 64'(1));
    chk("abort_words", 64'(rx_q.size()), 64'(ABORT_W));
    rst = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_hold", 64'(cpu_hold), 64'(0));
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    run_scan(-1, -1, ab);
    chk("rescan_count", 64'(rx_q.size()), 64'(exp_q.size()));
    if (rx_q.size() > 0)
      chk("rescan_first", pack(rx_q[0]), mk(2'd0, AW'(0), 32'h40, 1'b0));
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
